// File: rtl/johnson_pkg.sv
// Shared definitions for the Johnson counter monitor.
//   - FSM state encodings (localparam constants plus a matching enum)
//   - jc_next   : successor of a Johnson code of width w
//   - jc_decode : legality flag and phase index of a Johnson code of width w
// Both functions work on a zero-extended JC_MAX_W-bit code so that any
// instantiated WIDTH up to JC_MAX_W can share them.
package johnson_pkg;

    localparam int         JC_MAX_W = 32;
    localparam int         JC_PH_W  = 6;      // holds phases up to 2*JC_MAX_W-1
    localparam logic [7:0] ERR_MAX  = 8'd255;

    localparam logic [1:0] ST_SEARCH = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    typedef enum logic [1:0] {
        SEARCH = ST_SEARCH,
        CHECK  = ST_CHECK,
        LOCKED = ST_LOCKED
    } state_t;

    typedef struct packed {
        logic               legal;
        logic [JC_PH_W-1:0] phase;
    } jc_dec_t;

    // Shift right by one, feeding the inverted LSB into the MSB.
    function automatic logic [JC_MAX_W-1:0] jc_next(input logic [JC_MAX_W-1:0] code,
                                                    input int w);
        logic [JC_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < JC_MAX_W - 1; i++) begin
            if (i < w - 1) r[i] = code[i+1];
        end
        r[w-1] = ~code[0];
        return r;
    endfunction

    // With k = number of ones: a left-justified run of k ones is phase k;
    // otherwise a right-justified run of k ones (0 < k < w) is phase 2w-k.
    function automatic jc_dec_t jc_decode(input logic [JC_MAX_W-1:0] code,
                                          input int w);
        logic [JC_MAX_W-1:0] mask;
        int                  ones;
        jc_dec_t             d;
        mask = '0;
        ones = 0;
        for (int i = 0; i < JC_MAX_W; i++) begin
            if (i < w) begin
                mask[i] = 1'b1;
                ones    = ones + int'(code[i]);
            end
        end
        d = '0;
        if (code == (mask & ~(mask >> ones))) begin
            d.legal = 1'b1;
            d.phase = JC_PH_W'(ones);
        end else if (ones >= 1 && ones < w && code == (mask >> (w - ones))) begin
            d.legal = 1'b1;
            d.phase = JC_PH_W'(2 * w - ones);
        end
        return d;
    endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson code decoder.
//   jc    : WIDTH-bit Johnson code
//   legal : jc is one of the 2*WIDTH legal codes
//   phase : phase index of jc (0 when illegal)
module johnson_decode
    import johnson_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int PHASE_W = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0]   jc,
    output logic               legal,
    output logic [PHASE_W-1:0] phase
);

    jc_dec_t dec;
    logic    unused_dec;

    always_comb begin
        dec   = jc_decode(JC_MAX_W'(jc), WIDTH);
        legal = dec.legal;
        phase = dec.phase[PHASE_W-1:0];
    end

    // Upper phase bits are always zero for this WIDTH.
    assign unused_dec = ^dec.phase;

endmodule

// File: rtl/johnson_monitor.sv
// Johnson counter monitor: decodes each enabled sample, checks it is the
// successor of the previous one, locks after LOCK_N good steps, and counts
// revolutions (while locked) and sequence errors.
//   clk, rstn   : clock, synchronous active-low reset
//   en, jc_in   : sample enable and Johnson code
//   phase       : phase of last legal sample; phase_valid qualifies it
//   legal       : last sample was a legal code
//   locked      : sequence tracking locked
//   err_pulse   : one-cycle error strobe (not raised in SEARCH)
//   err_cnt     : saturating error count
//   wrap_cnt    : revolutions completed while locked (wraps)
module johnson_monitor
    import johnson_pkg::*;
#(
    parameter  int WIDTH   = 4,
    parameter  int LOCK_N  = 3,
    parameter  int CNT_W   = 8,
    localparam int PHASE_W = $clog2(2 * WIDTH)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic [WIDTH-1:0]   jc_in,
    output logic [PHASE_W-1:0] phase,
    output logic               phase_valid,
    output logic               legal,
    output logic               locked,
    output logic               err_pulse,
    output logic [7:0]         err_cnt,
    output logic [CNT_W-1:0]   wrap_cnt
);

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == ERR_MAX) ? v : v + 8'd1;
    endfunction

    state_t              state_p1;
    logic [WIDTH-1:0]    prev_p1;
    logic [3:0]          match_p1;

    logic                vld_p0;
    logic                legal_p0;
    logic [PHASE_W-1:0]  phase_p0;
    logic [JC_MAX_W-1:0] next_full_p0;
    logic                succ_p0;
    logic                unused_next;

    // ---- stage p0: decode and successor compare of the incoming sample ----
    johnson_decode #(
        .WIDTH   (WIDTH),
        .PHASE_W (PHASE_W)
    ) u_decode (
        .jc    (jc_in),
        .legal (legal_p0),
        .phase (phase_p0)
    );

    assign vld_p0       = en;
    assign next_full_p0 = jc_next(JC_MAX_W'(prev_p1), WIDTH);
    assign succ_p0      = (jc_in == next_full_p0[WIDTH-1:0]);
    assign unused_next  = ^next_full_p0;

    // ---- stage p1: tracking FSM and registered outputs ----
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_p1    <= SEARCH;
            prev_p1     <= '0;
            match_p1    <= '0;
            phase       <= '0;
            phase_valid <= 1'b0;
            legal       <= 1'b0;
            locked      <= 1'b0;
            err_pulse   <= 1'b0;
            err_cnt     <= '0;
            wrap_cnt    <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (vld_p0) begin
                legal <= legal_p0;
                if (state_p1 == SEARCH) begin
                    // Illegal codes are silently skipped until a legal seed arrives.
                    if (legal_p0) begin
                        prev_p1     <= jc_in;
                        phase       <= phase_p0;
                        phase_valid <= 1'b1;
                        match_p1    <= '0;
                        state_p1    <= CHECK;
                    end
                end else if (succ_p0) begin
                    prev_p1 <= jc_in;
                    phase   <= phase_p0;
                    if (state_p1 == LOCKED) begin
                        if (phase_p0 == '0) wrap_cnt <= wrap_cnt + CNT_W'(1);
                    end else begin
                        match_p1 <= match_p1 + 4'd1;
                        if (match_p1 == 4'(LOCK_N - 1)) begin
                            state_p1 <= LOCKED;
                            locked   <= 1'b1;
                        end
                    end
                end else begin
                    // Mismatch from CHECK or LOCKED: a legal code reseeds,
                    // an illegal one drops tracking entirely.
                    err_pulse <= 1'b1;
                    err_cnt   <= sat_inc(err_cnt);
                    locked    <= 1'b0;
                    if (legal_p0) begin
                        prev_p1  <= jc_in;
                        phase    <= phase_p0;
                        match_p1 <= '0;
                        state_p1 <= CHECK;
                    end else begin
                        phase_valid <= 1'b0;
                        state_p1    <= SEARCH;
                    end
                end
            end
        end
    end

endmodule
